// File: rtl/seg_display_scanner.sv
// Purpose: time-multiplexes six 7-segment patterns onto one shared segment bus and six digit anodes.
// Latency: all outputs are registered, one clock behind the scan state.
// Backpressure: none; the scan runs freely and the pattern inputs are sampled once per frame.
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   hour10_seg .. sec1_seg [6:0]      active-high segment patterns from the clock core
//   brightness [2:0]                  PWM duty within the on-window (0 = 1/8, 7 = full)
//   colon_en                          lights dp on the hour1 and min1 digits
//   blank_en                          forces the display dark from the next output cycle
//   seg_out [6:0], dp_out             shared segment bus and decimal point, polarity set by SEG_ACTIVE_LOW
//   an_out [5:0]                      digit enables, [0]=sec1 .. [5]=hour10, polarity set by AN_ACTIVE_LOW
//   frame_start                       one-cycle pulse in the first output cycle of each frame
module seg_display_scanner #(
  parameter int DIG_PERIOD     = 100000,
  parameter int BLANK_CYCLES   = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] hour10_seg,
  input  logic [6:0] hour1_seg,
  input  logic [6:0] min10_seg,
  input  logic [6:0] min1_seg,
  input  logic [6:0] sec10_seg,
  input  logic [6:0] sec1_seg,
  input  logic [2:0] brightness,
  input  logic       colon_en,
  input  logic       blank_en,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic [5:0] an_out,
  output logic       frame_start
);

  localparam int            CW        = $clog2(DIG_PERIOD);
  localparam logic [CW-1:0] SLOT_LAST = CW'(DIG_PERIOD - 1);
  localparam logic [CW-1:0] BLANK_V   = CW'(BLANK_CYCLES);

  logic [CW-1:0] slot_cnt;
  logic [2:0]    idx;
  logic [6:0]    snap_sec1, snap_sec10, snap_min1, snap_min10, snap_hour1, snap_hour10;
  logic [2:0]    bri_snap;
  logic          colon_snap;

  logic          frame_edge;
  logic [6:0]    seg_lit;
  logic [2:0]    pwm_phase;
  logic          on_phase;
  logic          lit;
  logic [5:0]    an_lit;
  logic          dp_lit;

  // First state cycle of a frame: idx 0, slot_cnt 0.
  assign frame_edge = (idx == 3'd0) && (slot_cnt == '0);

  // Scan counters: slot_cnt per digit slot, idx walks the six digits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_cnt <= '0;
      idx      <= 3'd0;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt <= '0;
      idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Whole-frame snapshot so a frame never mixes old and new time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_sec1   <= '0;
      snap_sec10  <= '0;
      snap_min1   <= '0;
      snap_min10  <= '0;
      snap_hour1  <= '0;
      snap_hour10 <= '0;
      bri_snap    <= 3'd7;
      colon_snap  <= 1'b0;
    end else if (frame_edge) begin
      snap_sec1   <= sec1_seg;
      snap_sec10  <= sec10_seg;
      snap_min1   <= min1_seg;
      snap_min10  <= min10_seg;
      snap_hour1  <= hour1_seg;
      snap_hour10 <= hour10_seg;
      bri_snap    <= brightness;
      colon_snap  <= colon_en;
    end
  end

  // In the snapshot cycle itself the registers still hold the previous
  // frame, so the sec1 pattern is taken straight from the input. This keeps
  // the whole idx-0 slot, blank part included, on the new frame's value.
  always_comb begin
    seg_lit = snap_sec1;
    case (idx)
      3'd0:    seg_lit = frame_edge ? sec1_seg : snap_sec1;
      3'd1:    seg_lit = snap_sec10;
      3'd2:    seg_lit = snap_min1;
      3'd3:    seg_lit = snap_min10;
      3'd4:    seg_lit = snap_hour1;
      3'd5:    seg_lit = snap_hour10;
      default: seg_lit = snap_sec1;
    endcase
  end

  // PWM phase is counted from the end of the blank window; only the low
  // three bits of the difference matter for a mod-8 phase.
  assign pwm_phase = slot_cnt[2:0] - BLANK_V[2:0];
  assign on_phase  = (slot_cnt >= BLANK_V);
  assign lit       = on_phase && (pwm_phase <= bri_snap) && !blank_en;
  assign an_lit    = lit ? (6'd1 << idx) : 6'd0;
  assign dp_lit    = colon_snap && ((idx == 3'd2) || (idx == 3'd4));

  // Output registers; XOR with the polarity flag maps active-high to pin level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_out      <= {6{AN_ACTIVE_LOW}};
      seg_out     <= {7{SEG_ACTIVE_LOW}};
      dp_out      <= SEG_ACTIVE_LOW;
      frame_start <= 1'b0;
    end else begin
      an_out      <= an_lit ^ {6{AN_ACTIVE_LOW}};
      seg_out     <= seg_lit ^ {7{SEG_ACTIVE_LOW}};
      dp_out      <= dp_lit ^ SEG_ACTIVE_LOW;
      frame_start <= frame_edge;
    end
  end

endmodule
